sr_tune_ctrl: RTL and testbench

Calibration sequencer for the fine/coarse thermometer shift-register pair (`L` fine stages feeding carries into `M` coarse stages). Converts a comparator decision into single-cycle step pulses: a coarse binary-sign search first, then fine tracking with lock detection. It sits beside the shift-register top level and drives its `comp_in`, `up`, `fine_en` and `coarse_en` inputs, and observes its `fine_out`/`coarse_out` codes for saturation.

---
 rtl/sr_tune_pkg.sv | 25 ++
 rtl/sr_tune_ctrl_sync2.sv | 27 ++
 rtl/sr_tune_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_sr_tune_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_tune_pkg.sv
// Shared constants for the fine/coarse delay-line calibration sequencer:
// FSM state encoding and the default timing and lock parameters.
package sr_tune_pkg;

  localparam int unsigned SETTLE_DEF     = 4;
  localparam int unsigned LOCK_CNT_DEF   = 8;
  localparam int unsigned UNLOCK_RUN_DEF = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_C_WAIT = 3'd1;
  localparam logic [2:0] ST_C_DEC  = 3'd2;
  localparam logic [2:0] ST_F_WAIT = 3'd3;
  localparam logic [2:0] ST_F_DEC  = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_C_WAIT = ST_C_WAIT,
    S_C_DEC  = ST_C_DEC,
    S_F_WAIT = ST_F_WAIT,
    S_F_DEC  = ST_F_DEC,
    S_ERROR  = ST_ERROR
  } state_t;

endpackage

// File: rtl/sr_tune_ctrl_sync2.sv
// Two-flop synchronizer for a single asynchronous level (the comparator).
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous input through two flops to resolve metastability.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking so both flops sample the values from before the edge;
      // blocking here would collapse the chain into a single flop.
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sr_tune_ctrl.sv
// Calibration sequencer: a coarse sign search followed by fine tracking with
// lock/unlock hysteresis. Emits one-cycle step pulses toward the shift-register
// pair and flags a step request at the code limit as a sticky saturation error.
module sr_tune_ctrl
  import sr_tune_pkg::*;
#(
  parameter int L          = 16,
  parameter int M          = 16,
  parameter int SETTLE     = SETTLE_DEF,
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int UNLOCK_RUN = UNLOCK_RUN_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         comp,
  input  logic [L-1:0] fine_code,
  input  logic [M-1:0] coarse_code,
  output logic         fine_en,
  output logic         coarse_en,
  output logic         up,
  output logic         sr_dir,
  output logic         busy,
  output logic         locked,
  output logic         sat_err
);

  // Settle counter only has to hold SETTLE-1; the lock counters must be able to
  // reach their thresholds, hence the +1 before $clog2.
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int AW = $clog2(LOCK_CNT + 1);
  localparam int RW = $clog2(UNLOCK_RUN + 1);

  state_t        r_state;
  logic [SW-1:0] r_settle_cnt;
  logic [AW-1:0] r_alt_cnt;
  logic [RW-1:0] r_run_cnt;
  logic          r_first;
  logic          r_prev_c;
  logic          r_prev_f;
  logic          r_fine_en;
  logic          r_coarse_en;
  logic          r_up;
  logic          r_sr_dir;
  logic          r_busy;
  logic          r_locked;
  logic          r_sat_err;

  logic          w_s;
  logic          w_c_limit;
  logic          w_f_limit;
  logic [AW-1:0] w_alt_nxt;
  logic [RW-1:0] w_run_nxt;

  sync2 u_comp_sync (
    .clk (clk),
    .rst (rst),
    .i_d (comp),
    .o_q (w_s)
  );

  // A coarse step is refused when the coarse code is already pinned in the
  // requested direction; a fine step only when both codes are pinned, since
  // fine carries roll into the coarse stage outside this block.
  assign w_c_limit = w_s ? coarse_code[M-1] : ~coarse_code[0];
  assign w_f_limit = w_s ? ((&fine_code) & (&coarse_code))
                         : (~(|fine_code) & ~(|coarse_code));

  // Next alternation / run counts for the fine sample being decided now.
  // A zero run count marks the first fine sample after entering the phase.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value held, which would infer a latch.
    w_alt_nxt = '0;
    w_run_nxt = RW'(1);
    if (r_run_cnt != '0) begin
      if (w_s != r_prev_f) begin
        w_alt_nxt = (r_alt_cnt == AW'(LOCK_CNT)) ? r_alt_cnt : r_alt_cnt + 1'b1;
      end else begin
        w_run_nxt = (r_run_cnt == RW'(UNLOCK_RUN)) ? r_run_cnt : r_run_cnt + 1'b1;
      end
    end
  end

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_alt_cnt    <= '0;
      r_run_cnt    <= '0;
      r_first      <= 1'b0;
      r_prev_c     <= 1'b0;
      r_prev_f     <= 1'b0;
      r_fine_en    <= 1'b0;
      r_coarse_en  <= 1'b0;
      r_up         <= 1'b0;
      r_sr_dir     <= 1'b0;
      r_busy       <= 1'b0;
      r_locked     <= 1'b0;
      r_sat_err    <= 1'b0;
    end else begin
      r_fine_en   <= 1'b0;
      r_coarse_en <= 1'b0;
      if (abort) begin
        r_state      <= S_IDLE;
        r_settle_cnt <= '0;
        r_alt_cnt    <= '0;
        r_run_cnt    <= '0;
        r_first      <= 1'b0;
        r_up         <= 1'b0;
        r_sr_dir     <= 1'b0;
        r_busy       <= 1'b0;
        r_locked     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_ERROR: begin
            if (start) begin
              r_state      <= S_C_WAIT;
              r_settle_cnt <= SW'(SETTLE - 1);
              r_first      <= 1'b1;
              r_sat_err    <= 1'b0;
              r_busy       <= 1'b1;
            end
          end
          S_C_WAIT: begin
            if (r_settle_cnt == '0) r_state <= S_C_DEC;
            else                    r_settle_cnt <= r_settle_cnt - 1'b1;
          end
          S_C_DEC: begin
            if (r_first || (w_s == r_prev_c)) begin
              if (w_c_limit) begin
                r_state   <= S_ERROR;
                r_sat_err <= 1'b1;
                r_busy    <= 1'b0;
                r_locked  <= 1'b0;
              end else begin
                r_coarse_en  <= 1'b1;
                r_up         <= w_s;
                r_prev_c     <= w_s;
                r_first      <= 1'b0;
                r_settle_cnt <= SW'(SETTLE - 1);
                r_state      <= S_C_WAIT;
              end
            end else begin
              // Sign flipped: the coarse stage has bracketed the target.
              r_alt_cnt    <= '0;
              r_run_cnt    <= '0;
              r_settle_cnt <= SW'(SETTLE - 1);
              r_state      <= S_F_WAIT;
            end
          end
          S_F_WAIT: begin
            if (r_settle_cnt == '0) r_state <= S_F_DEC;
            else                    r_settle_cnt <= r_settle_cnt - 1'b1;
          end
          S_F_DEC: begin
            if (w_f_limit) begin
              r_state   <= S_ERROR;
              r_sat_err <= 1'b1;
              r_busy    <= 1'b0;
              r_locked  <= 1'b0;
            end else begin
              r_fine_en    <= 1'b1;
              r_sr_dir     <= w_s;
              r_prev_f     <= w_s;
              r_alt_cnt    <= w_alt_nxt;
              r_run_cnt    <= w_run_nxt;
              r_settle_cnt <= SW'(SETTLE - 1);
              r_state      <= S_F_WAIT;
              if (w_alt_nxt == AW'(LOCK_CNT))        r_locked <= 1'b1;
              else if (w_run_nxt == RW'(UNLOCK_RUN)) r_locked <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fine_en   = r_fine_en;
  assign coarse_en = r_coarse_en;
  assign up        = r_up;
  assign sr_dir    = r_sr_dir;
  assign busy      = r_busy;
  assign locked    = r_locked;
  assign sat_err   = r_sat_err;

endmodule

// File: tb/tb_sr_tune_ctrl.sv
// Bench for sr_tune_ctrl: directed scenarios with hand-computed expectations,
// then randomized stimulus, all compared every cycle against a behavioural
// model that schedules decisions by absolute cycle number and derives lock
// state from the history of fine samples.
module tb_sr_tune_ctrl;

  localparam int L          = 16;
  localparam int M          = 16;
  localparam int SETTLE     = 4;
  localparam int LOCK_CNT   = 8;
  localparam int UNLOCK_RUN = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         comp = 1'b0;
  logic [L-1:0] fine_code = '0;
  logic [M-1:0] coarse_code = '0;
  logic         fine_en, coarse_en, up, sr_dir, busy, locked, sat_err;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  sr_tune_ctrl #(
    .L(L), .M(M), .SETTLE(SETTLE), .LOCK_CNT(LOCK_CNT), .UNLOCK_RUN(UNLOCK_RUN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .comp        (comp),
    .fine_code   (fine_code),
    .coarse_code (coarse_code),
    .fine_en     (fine_en),
    .coarse_en   (coarse_en),
    .up          (up),
    .sr_dir      (sr_dir),
    .busy        (busy),
    .locked      (locked),
    .sat_err     (sat_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_COARSE, M_FINE, M_ERR} mphase_t;
  mphase_t mph = M_IDLE;
  int      cyc = 0;
  int      next_at = 0;
  bit      first_c, prev_c;
  bit      fq[$];
  bit      sh0, sh1;
  bit      e_fine_en, e_coarse_en, e_up, e_sr_dir, e_busy, e_locked, e_sat;

  function automatic int tail_alt();
    int a = 0;
    for (int i = fq.size() - 1; i > 0; i--) begin
      if (fq[i] != fq[i-1]) a++;
      else break;
    end
    return a;
  endfunction

  function automatic int tail_run();
    int r = 1;
    for (int i = fq.size() - 1; i > 0; i--) begin
      if (fq[i] == fq[i-1]) r++;
      else break;
    end
    return r;
  endfunction

  task automatic model_reset();
    mph = M_IDLE; sh0 = 0; sh1 = 0; first_c = 0; prev_c = 0; fq.delete();
    e_fine_en = 0; e_coarse_en = 0; e_up = 0; e_sr_dir = 0;
    e_busy = 0; e_locked = 0; e_sat = 0;
  endtask

  task automatic model_err();
    mph = M_ERR; e_sat = 1; e_busy = 0; e_locked = 0;
  endtask

  task automatic model_edge();
    bit s;
    s = sh1; sh1 = sh0; sh0 = comp;   // comparator seen two edges late
    cyc++;
    e_fine_en = 0; e_coarse_en = 0;
    if (abort) begin
      mph = M_IDLE; e_busy = 0; e_locked = 0;
    end else begin
      case (mph)
        M_IDLE, M_ERR: if (start) begin
          mph = M_COARSE; next_at = cyc + SETTLE + 1; first_c = 1; e_sat = 0; e_busy = 1;
        end
        M_COARSE: if (cyc == next_at) begin
          next_at = cyc + SETTLE + 1;
          if (first_c || s == prev_c) begin
            if ((s && coarse_code[M-1]) || (!s && !coarse_code[0])) model_err();
            else begin e_coarse_en = 1; e_up = s; prev_c = s; first_c = 0; end
          end else begin
            mph = M_FINE; fq.delete();
          end
        end
        M_FINE: if (cyc == next_at) begin
          next_at = cyc + SETTLE + 1;
          if ((s && fine_code == '1 && coarse_code == '1) ||
              (!s && fine_code == '0 && coarse_code == '0)) model_err();
          else begin
            e_fine_en = 1; e_sr_dir = s;
            fq.push_back(s);
            if (fq.size() > 32) void'(fq.pop_front());
            if (tail_alt() >= LOCK_CNT)        e_locked = 1;
            else if (tail_run() >= UNLOCK_RUN) e_locked = 0;
          end
        end
        default: mph = M_IDLE;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) model_reset();
    else      model_edge();
  end

  // Compare DUT against model on every falling edge.
  initial forever begin
    @(negedge clk);
    check("fine_en",   fine_en,   e_fine_en);
    check("coarse_en", coarse_en, e_coarse_en);
    check("busy",      busy,      e_busy);
    check("locked",    locked,    e_locked);
    check("sat_err",   sat_err,   e_sat);
    if (e_coarse_en) check("up", up, e_up);
    if (e_fine_en)   check("sr_dir", sr_dir, e_sr_dir);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_therm();
    int r;
    int k;
    logic [31:0] v;
    r = $urandom_range(0, 99);
    if (r < 20)      k = 0;
    else if (r < 40) k = 16;
    else             k = $urandom_range(1, 15);
    v = (32'h1 << k) - 32'h1;
    return v[15:0];
  endfunction

  int tc[8];
  int nc, t_f, fp, np, mode;
  bit got_f;

  initial begin
    // Reset held with start high and comp toggling.
    rst = 0; start = 1;
    for (int i = 0; i < 6; i++) begin tick(); comp = ~comp; end
    check("rst_fine_en", fine_en, 0);
    check("rst_coarse_en", coarse_en, 0);
    check("rst_busy", busy, 0);
    check("rst_locked", locked, 0);
    check("rst_sat_err", sat_err, 0);
    start = 0; tick(); rst = 1; tick(); tick();
    check("idle_busy", busy, 0);

    // Coarse search: three up steps, then sign flips into fine.
    fine_code = 16'h00FF; coarse_code = 16'h00FF; comp = 1;
    tick(); tick(); tick();
    start = 1; tick(); start = 0;
    check("start_busy", busy, 1);
    nc = 0; t_f = -1;
    for (int t = 1; t <= 40 && t_f < 0; t++) begin
      tick();
      if (coarse_en) begin
        if (nc < 8) tc[nc] = t;
        nc++;
        check("coarse_up", up, 1);
        if (nc == 3) comp = 0;
      end
      if (fine_en) t_f = t;
    end
    check("coarse_pulses", nc, 3);
    check("coarse_first_t", tc[0], SETTLE + 1);
    check("coarse_gap1", tc[1] - tc[0], SETTLE + 1);
    check("coarse_gap2", tc[2] - tc[1], SETTLE + 1);
    check("fine_first_t", t_f, 25);
    check("fine_first_dir", sr_dir, 0);

    // Lock: alternate comp every sample; 9th fine sample is the 8th alternation.
    fp = 1; comp = 1;
    for (int t = 0; t < 200 && fp < 9; t++) begin
      tick();
      if (fine_en) begin
        fp++;
        check("lock_dir", sr_dir, (fp % 2 == 0) ? 1 : 0);
        if (fp == 8) check("pre_lock", locked, 0);
        if (fp == 9) check("lock", locked, 1);
        comp = ~comp;
      end
    end

    // Unlock: four identical samples of 1.
    for (int t = 0; t < 200 && fp < 13; t++) begin
      tick();
      if (fine_en) begin
        fp++;
        check("unlock_dir", sr_dir, 1);
        if (fp == 12) check("still_locked", locked, 1);
        if (fp == 13) check("unlock", locked, 0);
      end
    end
    check("fine_pulses", fp, 13);

    // Re-lock, then abort during the settle wait.
    for (int t = 0; t < 300 && !locked; t++) begin
      tick();
      if (fine_en) comp = ~comp;
    end
    check("relock", locked, 1);
    tick(); tick();
    abort = 1; tick(); abort = 0;
    check("abort_busy", busy, 0);
    check("abort_locked", locked, 0);
    np = 0;
    repeat (20) begin tick(); if (fine_en || coarse_en) np++; end
    check("abort_quiet", np, 0);

    // Saturation: coarse code full and comp up on the first sample.
    coarse_code = 16'hFFFF; comp = 1;
    tick(); tick(); tick();
    start = 1; tick(); start = 0;
    np = 0;
    repeat (8) begin tick(); if (coarse_en) np++; end
    check("sat_nopulse", np, 0);
    check("sat_err", sat_err, 1);
    check("sat_busy", busy, 0);
    coarse_code = 16'h0000;
    start = 1; tick(); start = 0;
    check("sat_clear", sat_err, 0);
    check("restart_busy", busy, 1);

    // Reset asserted while a fine pulse is high.
    coarse_code = 16'h00FF; got_f = 0;
    for (int t = 0; t < 80 && !got_f; t++) begin
      tick();
      if (coarse_en) comp = 0;
      if (fine_en) got_f = 1;
    end
    if (got_f) begin
      #1 rst = 0;
      #1 check("rst_pulse_fine_en", fine_en, 0);
      check("rst_pulse_busy", busy, 0);
    end else begin
      check("reach_fine", 0, 1);
    end
    tick(); tick(); rst = 1; tick();

    // Randomized phase with comparator behaviour modes.
    mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) mode = $urandom_range(0, 2);
      tick();
      case (mode)
        0:       if ($urandom_range(0, 9) < 3) comp = ~comp;
        1:       if (fine_en || coarse_en) comp = ~comp;
        default: if ($urandom_range(0, 49) == 0) comp = ~comp;
      endcase
      start = ($urandom_range(0, 99) < 4);
      abort = ($urandom_range(0, 299) < 2);
      if ($urandom_range(0, 19) == 0) fine_code = rand_therm();
      if ($urandom_range(0, 19) == 0) coarse_code = rand_therm();
    end
    start = 0; abort = 0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
